// File: rtl/reg1_pkg.sv
// Shared definitions for the reg1 register family: default word width and
// the serializer state encoding.
package reg1_pkg;

  localparam int REG1_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2
  } state_t;

endpackage

// File: rtl/reg1_bit_ctr.sv
// Bit-position counter for the serializer: synchronous active-low clear,
// increment enable and a terminal-count flag at WIDTH-1.
module reg1_bit_ctr
  import reg1_pkg::*;
#(
  parameter int WIDTH = REG1_WIDTH,
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  logic [CW-1:0] cnt_reg;

  // Clear has priority so a new word always starts from bit 0.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      cnt_reg <= '0;
    end else if (inc) begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign cnt = cnt_reg;
  assign tc  = (cnt_reg == CW'(WIDTH - 1));

endmodule

// File: rtl/reg1_piso_tx.sv
// Parallel-in serial-out transmitter: takes a word over valid/ready and shifts
// it out LSB first with first/last framing and an optional even-parity beat.
module reg1_piso_tx
  import reg1_pkg::*;
#(
  parameter int WIDTH  = REG1_WIDTH,
  parameter int PARITY = 0
) (
  input  logic             clk,
  input  logic             en,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] numin,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shreg_reg;
  logic [WIDTH-1:0] shift_val;
  logic             par_reg;
  logic [CW-1:0]    cnt;
  logic             tc;
  logic             load_fire;
  logic             shift_fire;

  assign load_fire  = (state_reg == S_IDLE) && load_valid;
  assign shift_fire = (state_reg == S_SHIFT) && ser_ready;

  // Right shift with zero fill at the MSB.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
    if (gi == WIDTH - 1) begin : g_msb
      assign shift_val[gi] = 1'b0;
    end else begin : g_lo
      assign shift_val[gi] = shreg_reg[gi+1];
    end
  end

  reg1_bit_ctr #(.WIDTH(WIDTH)) u_ctr (
    .clk   (clk),
    .clr_n (en && !load_fire),
    .inc   (shift_fire),
    .cnt   (cnt),
    .tc    (tc)
  );

  always_ff @(posedge clk) begin
    if (!en) begin
      state_reg <= S_IDLE;
      shreg_reg <= '0;
      par_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (load_fire) begin
        shreg_reg <= numin;
        par_reg   <= ^numin;
      end else if (shift_fire) begin
        shreg_reg <= shift_val;
      end
    end
  end

  // Outputs depend only on registered state, so nothing is held up by ser_ready.
  always_comb begin
    state_next = state_reg;
    load_ready = 1'b0;
    ser_valid  = 1'b0;
    ser_out    = 1'b0;
    ser_first  = 1'b0;
    ser_last   = 1'b0;
    busy       = (state_reg != S_IDLE);
    case (state_reg)
      S_IDLE: begin
        load_ready = 1'b1;
        if (load_valid) state_next = S_SHIFT;
      end
      S_SHIFT: begin
        ser_valid = 1'b1;
        ser_out   = shreg_reg[0];
        ser_first = (cnt == '0);
        ser_last  = tc && (PARITY == 0);
        if (ser_ready && tc) state_next = (PARITY != 0) ? S_PARITY : S_IDLE;
      end
      S_PARITY: begin
        ser_valid = 1'b1;
        ser_out   = par_reg;
        ser_last  = 1'b1;
        if (ser_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg1_piso_tx.sv
// Bench for reg1_piso_tx: one instance without and one with the parity beat,
// both checked every cycle against a queue-of-beats reference model.
module tb_reg1_piso_tx;

  logic       clk;
  logic       en;
  logic       load_valid;
  logic [3:0] numin;
  logic       ser_ready;

  logic ld_rdy0, out0, val0, first0, last0, busy0;
  logic ld_rdy1, out1, val1, first1, last1, busy1;

  int checks = 0;
  int errors = 0;

  // Reference model: pending beats of the current frame, front = beat on the wire.
  bit q0[$];
  bit q1[$];
  int pos0 = 0;
  int pos1 = 0;

  reg1_piso_tx #(.WIDTH(4), .PARITY(0)) dut0 (
    .clk(clk), .en(en), .load_valid(load_valid), .load_ready(ld_rdy0),
    .numin(numin), .ser_out(out0), .ser_valid(val0), .ser_ready(ser_ready),
    .ser_first(first0), .ser_last(last0), .busy(busy0)
  );

  reg1_piso_tx #(.WIDTH(4), .PARITY(1)) dut1 (
    .clk(clk), .en(en), .load_valid(load_valid), .load_ready(ld_rdy1),
    .numin(numin), .ser_out(out1), .ser_valid(val1), .ser_ready(ser_ready),
    .ser_first(first1), .ser_last(last1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    int ones;
    if (!en) begin
      q0.delete();
      q1.delete();
      pos0 = 0;
      pos1 = 0;
    end else begin
      if (q0.size() == 0) begin
        if (load_valid) begin
          for (int i = 0; i < 4; i++) q0.push_back(numin[i]);
          pos0 = 0;
          $display("LOAD p0 numin=%b t=%0t", numin, $time);
        end
      end else if (ser_ready) begin
        void'(q0.pop_front());
        pos0++;
      end
      if (q1.size() == 0) begin
        if (load_valid) begin
          ones = 0;
          for (int i = 0; i < 4; i++) begin
            q1.push_back(numin[i]);
            ones += int'(numin[i]);
          end
          q1.push_back(bit'(ones % 2));
          pos1 = 0;
          $display("LOAD p1 numin=%b t=%0t", numin, $time);
        end
      end else if (ser_ready) begin
        void'(q1.pop_front());
        pos1++;
      end
    end
  endtask

  task automatic compare_all();
    logic e_out0, e_out1;
    e_out0 = (q0.size() != 0) ? q0[0] : 1'b0;
    e_out1 = (q1.size() != 0) ? q1[0] : 1'b0;
    chk("p0_load_ready", {3'b0, ld_rdy0}, {3'b0, q0.size() == 0});
    chk("p0_ser_valid",  {3'b0, val0},    {3'b0, q0.size() != 0});
    chk("p0_ser_out",    {3'b0, out0},    {3'b0, e_out0});
    chk("p0_ser_first",  {3'b0, first0},  {3'b0, (q0.size() != 0) && (pos0 == 0)});
    chk("p0_ser_last",   {3'b0, last0},   {3'b0, q0.size() == 1});
    chk("p0_busy",       {3'b0, busy0},   {3'b0, q0.size() != 0});
    if (q0.size() != 0) chk("p0_cnt", {2'b0, dut0.cnt}, pos0[3:0]);
    chk("p1_load_ready", {3'b0, ld_rdy1}, {3'b0, q1.size() == 0});
    chk("p1_ser_valid",  {3'b0, val1},    {3'b0, q1.size() != 0});
    chk("p1_ser_out",    {3'b0, out1},    {3'b0, e_out1});
    chk("p1_ser_first",  {3'b0, first1},  {3'b0, (q1.size() != 0) && (pos1 == 0)});
    chk("p1_ser_last",   {3'b0, last1},   {3'b0, q1.size() == 1});
    chk("p1_busy",       {3'b0, busy1},   {3'b0, q1.size() != 0});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    en         = 1'b0;
    load_valid = 1'b1;
    numin      = 4'hC;
    ser_ready  = 1'b1;
    // Reset with a load request present: reset must win.
    run(2);
    en         = 1'b1;
    load_valid = 1'b0;
    run(1);

    // 1011 with ser_ready held high.
    numin = 4'b1011; load_valid = 1'b1;
    step();
    load_valid = 1'b0; numin = 4'h0;
    run(7);

    // 0111: parity instance adds a trailing 1.
    numin = 4'b0111; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    run(7);

    // 0101 stalled for three cycles at beat 2.
    numin = 4'b0101; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    run(2);
    ser_ready = 1'b0;
    run(3);
    ser_ready = 1'b1;
    run(5);

    // Load attempt while busy must not disturb the frame.
    numin = 4'b0010; load_valid = 1'b1;
    step();
    numin = 4'hF;
    run(2);
    load_valid = 1'b0;
    run(5);

    // Reset during beat 2 aborts the frame.
    numin = 4'b1101; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    run(2);
    en = 1'b0;
    run(1);
    en = 1'b1;
    run(2);

    // Continuous load_valid: A then 5, one idle cycle between frames.
    numin = 4'hA; load_valid = 1'b1;
    step();
    numin = 4'h5;
    run(6);
    load_valid = 1'b0;
    run(6);

    // Randomized traffic with backpressure and occasional resets.
    for (int i = 0; i < 400; i++) begin
      load_valid = ($urandom_range(0, 99) < 40);
      numin      = 4'($urandom_range(0, 15));
      ser_ready  = ($urandom_range(0, 99) < 70);
      en         = ($urandom_range(0, 99) >= 3);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
